// File: rtl/floor_request_scheduler.sv
// == floor_request_scheduler: button debounce, SCAN target selection, valid/ready offer -- rev 1.0 ==
`default_nettype none

module floor_request_scheduler #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic [1:0] current_level,
  input  logic       arrived,
  input  logic       target_ready,
  output logic       target_valid,
  output logic [1:0] target_floor,
  output logic       direction,
  output logic [3:0] pending
);

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] deb_q, deb_d;
  logic [3:0] rise;
  logic [3:0] pending_q, pending_d;
  logic [1:0] tfloor_q, tfloor_d;
  logic       dir_q, dir_d;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_deb
    logic [7:0] cnt_q, cnt_d;
    logic       differ, hit;

    assign differ     = (btn[gi] != deb_q[gi]);
    assign hit        = differ && (cnt_q == DEB_LAST);
    assign cnt_d      = (differ && !hit) ? cnt_q + 8'd1 : 8'd0;
    assign deb_d[gi]  = hit ? ~deb_q[gi] : deb_q[gi];
    assign rise[gi]   = hit & ~deb_q[gi];

    always_ff @(posedge clk) begin
      if (!reset) cnt_q <= 8'd0;
      else        cnt_q <= cnt_d;
    end
  end

  // An arrival clear overrides a debounced rise on the same floor.
  always_comb begin
    pending_d = pending_q | rise;
    if (arrived) pending_d[current_level] = 1'b0;
  end

  // Nearest pending floor above and below the current level.
  logic       up_hit, dn_hit;
  logic [1:0] up_floor, dn_floor;
  always_comb begin
    up_hit   = 1'b0;
    dn_hit   = 1'b0;
    up_floor = 2'd0;
    dn_floor = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i] && (2'(i) > current_level)) begin
        up_hit   = 1'b1;
        up_floor = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pending_q[i] && (2'(i) < current_level)) begin
        dn_hit   = 1'b1;
        dn_floor = 2'(i);
      end
    end
  end

  logic [1:0] sel_floor;
  logic       sel_dir;
  always_comb begin
    sel_floor = current_level;
    sel_dir   = dir_q;
    if (dir_q) begin
      if (up_hit)      begin sel_floor = up_floor; sel_dir = 1'b1; end
      else if (dn_hit) begin sel_floor = dn_floor; sel_dir = 1'b0; end
    end else begin
      if (dn_hit)      begin sel_floor = dn_floor; sel_dir = 1'b0; end
      else if (up_hit) begin sel_floor = up_floor; sel_dir = 1'b1; end
    end
  end

  always_comb begin
    state_d  = state_q;
    tfloor_d = tfloor_q;
    dir_d    = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          state_d  = ST_OFFER;
          tfloor_d = sel_floor;
          dir_d    = sel_dir;
        end
      end
      ST_OFFER: if (target_ready) state_d = ST_WAIT;
      ST_WAIT:  if (arrived)      state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      deb_q     <= 4'd0;
      pending_q <= 4'd0;
      tfloor_q  <= 2'd0;
      dir_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      pending_q <= pending_d;
      tfloor_q  <= tfloor_d;
      dir_q     <= dir_d;
    end
  end

  assign target_valid = (state_q == ST_OFFER);
  assign target_floor = tfloor_q;
  assign direction    = dir_q;
  assign pending      = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_floor_request_scheduler.sv
// == tb_floor_request_scheduler: directed self-checking bench for floor_request_scheduler -- rev 1.0 ==
`default_nettype none

module tb_floor_request_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [1:0] current_level;
  logic       arrived;
  logic       target_ready;
  logic       target_valid;
  logic [1:0] target_floor;
  logic       direction;
  logic [3:0] pending;

  int n_total = 0;
  int n_pass  = 0;

  floor_request_scheduler #(.DEBOUNCE_CYCLES(4)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .current_level (current_level),
    .arrived       (arrived),
    .target_ready  (target_ready),
    .target_valid  (target_valid),
    .target_floor  (target_floor),
    .direction     (direction),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else             n_pass++;
  endtask

  // Advance one rising edge; inputs driven and outputs sampled 1 ns after it.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0; btn = 4'b0000; current_level = 2'd0;
    arrived = 1'b0; target_ready = 1'b0;

    // Reset and glitch rejection
    step(2);
    check("rst_pending", 8'(pending), 8'h0);
    check("rst_valid",   8'(target_valid), 8'h0);
    check("rst_dir",     8'(direction), 8'h1);
    check("rst_floor",   8'(target_floor), 8'h0);
    reset = 1'b1;
    btn = 4'b0010;
    step(3);
    btn = 4'b0000;
    target_ready = 1'b1;
    step(3);
    check("glitch_pending", 8'(pending), 8'h0);
    check("glitch_valid",   8'(target_valid), 8'h0);
    check("glitch_dir",     8'(direction), 8'h1);
    target_ready = 1'b0;

    // Single request and handshake
    current_level = 2'd0;
    btn = 4'b0100;
    step(3);
    check("press_before4", 8'(pending), 8'h0);
    step(1);
    check("press_at4", 8'(pending), 8'h4);
    check("press_novalid", 8'(target_valid), 8'h0);
    step(1);
    check("offer_valid", 8'(target_valid), 8'h1);
    check("offer_floor", 8'(target_floor), 8'h2);
    check("offer_dir",   8'(direction), 8'h1);
    step(3);
    check("offer_hold_valid", 8'(target_valid), 8'h1);
    check("offer_hold_floor", 8'(target_floor), 8'h2);
    check("hold_one_request", 8'(pending), 8'h4);
    target_ready = 1'b1;
    step(1);
    target_ready = 1'b0;
    check("hs_drop_valid", 8'(target_valid), 8'h0);
    step(1);
    btn = 4'b0000;
    current_level = 2'd2;
    arrived = 1'b1;
    step(1);
    arrived = 1'b0;
    check("arrive_clear", 8'(pending), 8'h0);
    step(6);
    check("idle_after_arrive", 8'(target_valid), 8'h0);
    check("release_no_req", 8'(pending), 8'h0);

    // SCAN ordering from floor 1 going up with floors 0 and 3 pending
    current_level = 2'd1;
    btn = 4'b1001;
    step(4);
    check("scan_pending", 8'(pending), 8'h9);
    step(1);
    check("scan1_valid", 8'(target_valid), 8'h1);
    check("scan1_floor", 8'(target_floor), 8'h3);
    check("scan1_dir",   8'(direction), 8'h1);
    target_ready = 1'b1;
    btn = 4'b0000;
    step(1);
    target_ready = 1'b0;
    current_level = 2'd3;
    arrived = 1'b1;
    step(1);
    arrived = 1'b0;
    check("scan_arr3_pending", 8'(pending), 8'h1);
    check("scan_arr3_valid",   8'(target_valid), 8'h0);
    step(1);
    check("scan2_valid", 8'(target_valid), 8'h1);
    check("scan2_floor", 8'(target_floor), 8'h0);
    check("scan2_dir",   8'(direction), 8'h0);
    target_ready = 1'b1;
    step(1);
    target_ready = 1'b0;
    current_level = 2'd0;
    arrived = 1'b1;
    step(1);
    arrived = 1'b0;
    check("scan_done", 8'(pending), 8'h0);
    step(4);

    // Current-floor request keeps direction (currently down)
    current_level = 2'd2;
    btn = 4'b0100;
    step(5);
    check("cur_valid", 8'(target_valid), 8'h1);
    check("cur_floor", 8'(target_floor), 8'h2);
    check("cur_dir",   8'(direction), 8'h0);
    target_ready = 1'b1;
    btn = 4'b0000;
    step(1);
    target_ready = 1'b0;
    arrived = 1'b1;
    step(1);
    arrived = 1'b0;
    check("cur_clear", 8'(pending), 8'h0);
    step(4);

    // Debounced rise on floor 1 coinciding with arrival at floor 1
    current_level = 2'd1;
    btn = 4'b0010;
    step(3);
    arrived = 1'b1;
    step(1);
    arrived = 1'b0;
    check("clear_wins", 8'(pending), 8'h0);
    step(1);
    check("clear_wins_idle", 8'(target_valid), 8'h0);
    btn = 4'b0000;
    step(6);
    check("clear_wins_later", 8'(pending), 8'h0);

    // Mid-operation reset while waiting for arrival
    current_level = 2'd3;
    btn = 4'b1110;
    step(5);
    check("mid_floor", 8'(target_floor), 8'h2);
    check("mid_dir",   8'(direction), 8'h0);
    target_ready = 1'b1;
    btn = 4'b0000;
    step(1);
    target_ready = 1'b0;
    check("mid_wait_pending", 8'(pending), 8'he);
    check("mid_wait_valid",   8'(target_valid), 8'h0);
    step(5);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("mid_rst_pending", 8'(pending), 8'h0);
    check("mid_rst_valid",   8'(target_valid), 8'h0);
    check("mid_rst_dir",     8'(direction), 8'h1);
    current_level = 2'd0;
    btn = 4'b1000;
    step(4);
    check("post_rst_pending", 8'(pending), 8'h8);
    step(1);
    check("post_rst_valid", 8'(target_valid), 8'h1);
    check("post_rst_floor", 8'(target_floor), 8'h3);
    check("post_rst_dir",   8'(direction), 8'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
